clause_bram_reader: RTL and testbench

Read-side master for the clause dual-port BRAM (port B). On a start command it fetches a contiguous run of clause words from a base address, absorbs the 1-cycle BRAM read latency, and presents the words on a valid/ready stream to the clause-evaluation datapath. It is the counterpart to the port-A writer that loads clause words into the BRAM.

---
 rtl/clause_bram_pkg.sv | 20 ++
 rtl/clause_rd_skid.sv | 68 ++++++
 rtl/clause_bram_reader.sv | 154 +++++++++++++++
 tb/tb_clause_bram_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_bram_pkg.sv
// clause_bram_pkg
// Shared definitions for the clause BRAM read side: default BRAM geometry,
// the reader FSM state type and the depth of the output skid buffer.
// No ports (package only).
package clause_bram_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 256;

  // Two entries are enough to hide the one-cycle BRAM latency at full rate.
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/clause_rd_skid.sv
// clause_rd_skid
// Two-entry FIFO that catches BRAM read data and presents it as the head of
// the output stream, together with a per-entry "last word of run" flag.
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset (0 = empty the buffer)
//   push       write push_data/push_last into the tail
//   push_data  word captured from the BRAM
//   push_last  word is the final one of the run
//   pop        remove the head entry (caller guarantees non-empty)
//   head_data  word at the head
//   head_last  last flag of the head entry
//   occupancy  number of entries held, 0..2
module clause_rd_skid
  import clause_bram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] data_reg [SKID_DEPTH];
  logic                  last_reg [SKID_DEPTH];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;

  // Entries are cleared on reset so the stream data reads as zero afterwards.
  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!reset) begin
          data_reg[gi] <= '0;
          last_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg[gi] <= push_data;
          last_reg[gi] <= push_last;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      // Push and pop together leave the count unchanged.
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  assign head_data = data_reg[rd_ptr_reg];
  assign head_last = last_reg[rd_ptr_reg];
  assign occupancy = count_reg;

endmodule

// File: rtl/clause_bram_reader.sv
// clause_bram_reader
// Port-B read master for the clause BRAM. A start command fetches num_words
// consecutive words from base_addr (address wraps at 2^ADDR_WIDTH), absorbs
// the one-cycle BRAM latency in a 2-entry skid buffer and streams the words
// out on a valid/ready interface.
// Optional feature macro: CLAUSE_RD_CHECKSUM_EN adds a running-XOR checksum
// of all words transferred in the current run.
// Ports:
//   clkb       clock (also the BRAM port-B clock)
//   reset      synchronous, active-low reset
//   start      command strobe, only sampled in IDLE
//   base_addr  first word address of the run
//   num_words  run length, 0..2^ADDR_WIDTH
//   busy       high from accepted start through the done cycle
//   done       one-cycle pulse after the last word is accepted
//   enb/addrb  BRAM port-B read enable and address
//   doutb      BRAM port-B read data (one cycle after enb)
//   m_valid/m_ready/m_data/m_last  output word stream
//   checksum   XOR of transferred words (CLAUSE_RD_CHECKSUM_EN only)
module clause_bram_reader
  import clause_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clkb,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef CLAUSE_RD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  rd_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   issue_cnt_reg;
  logic [ADDR_WIDTH:0]   accept_cnt_reg;
  logic                  in_flight_reg;
  logic                  in_flight_last_reg;
  logic [1:0]            occupancy;
  logic                  head_last;
  logic                  xfer;
  logic [2:0]            committed;
  logic                  issue_ok;

  assign xfer = m_valid && m_ready;

  // Slots already spoken for: buffered words plus the read in flight. A pop
  // in this same cycle frees a slot in time for the new read's data, which
  // is what sustains one word per cycle with m_ready held high.
  assign committed = {1'b0, occupancy} + {2'b0, in_flight_reg} - {2'b0, xfer};
  assign issue_ok  = (committed < 3'd2);

  always_comb begin
    state_next = state_reg;
    enb        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_words != '0) ? READ : DONE;
      end
      READ: begin
        if (issue_ok) begin
          enb = 1'b1;
          if (issue_cnt_reg == CNT_ONE) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && (accept_cnt_reg == CNT_ONE)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkb) begin
    if (!reset) begin
      state_reg          <= IDLE;
      addr_reg           <= '0;
      issue_cnt_reg      <= '0;
      accept_cnt_reg     <= '0;
      in_flight_reg      <= 1'b0;
      in_flight_last_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      in_flight_reg      <= enb;
      in_flight_last_reg <= enb && (issue_cnt_reg == CNT_ONE);
      if ((state_reg == IDLE) && start && (num_words != '0)) begin
        addr_reg       <= base_addr;
        issue_cnt_reg  <= num_words;
        accept_cnt_reg <= num_words;
      end else begin
        if (enb) begin
          addr_reg      <= addr_reg + 1'b1;  // natural wrap at 2^ADDR_WIDTH
          issue_cnt_reg <= issue_cnt_reg - 1'b1;
        end
        if (xfer) accept_cnt_reg <= accept_cnt_reg - 1'b1;
      end
    end
  end

  // Read data lands one cycle after the issue; the last flag travels with it.
  clause_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clkb),
    .reset     (reset),
    .push      (in_flight_reg),
    .push_data (doutb),
    .push_last (in_flight_last_reg),
    .pop       (xfer),
    .head_data (m_data),
    .head_last (head_last),
    .occupancy (occupancy)
  );

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign addrb   = addr_reg;
  assign m_valid = (occupancy != 2'd0);
  assign m_last  = m_valid && head_last;

`ifdef CLAUSE_RD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_reg;

  always_ff @(posedge clkb) begin
    if (!reset) begin
      checksum_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      checksum_reg <= '0;
    end else if (xfer) begin
      checksum_reg <= checksum_reg ^ m_data;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_clause_bram_reader.sv
// tb_clause_bram_reader
// Self-checking bench for clause_bram_reader: a behavioural BRAM, a table of
// directed runs, hand-written reset sequences and randomized runs with random
// backpressure. Expected streams come from the BRAM array and modular address
// arithmetic. Build with CLAUSE_RD_CHECKSUM_EN to also cover the checksum.
module tb_clause_bram_reader;

  localparam int AW     = 10;
  localparam int DW     = 256;
  localparam int DEPTH  = 1 << AW;
  localparam int BUDGET = 3000;

  logic          clkb = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, enb, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;
  logic [DW-1:0] m_data;
`ifdef CLAUSE_RD_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  clause_bram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clkb      (clkb),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef CLAUSE_RD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clkb = ~clkb;

  // Behavioural BRAM port B: registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clkb) if (enb) doutb <= mem[addrb];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state for the run in progress.
  bit            run_active = 1'b0;
  int            run_base, run_num, issued, xfers;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_data;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clkb) begin
    if (run_active) begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (enb) begin
        check("issue_addr", addrb, (run_base + issued) % DEPTH);
        issued++;
        check("issue_within_run", issued <= run_num, 1'b1);
      end
      if (m_valid && m_ready) begin
        if (xfers < exp_q.size()) check("stream_data", m_data, exp_q[xfers]);
        else check("stream_extra", xfers, exp_q.size());
        check("stream_last", m_last, (xfers + 1) == run_num);
        last_data = m_data;
        xfers++;
      end
      check("outstanding", (issued - xfers) <= 2, 1'b1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  function automatic logic ready_for(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (idx % 3) == 0;  // 1,0,0,1,0,0,...
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_case(input logic [AW-1:0] b, input int n, input int mode, input bit mid,
                          input int exp_lat, input logic [DW-1:0] exp_last, input int tag);
    int  idx;
    int  lat;
    bit  seen;
    time t_acc;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
    run_base = int'(b); run_num = n; issued = 0; xfers = 0;
    prev_stall = 1'b0; last_data = '0; lat = -1; seen = 1'b0;
    @(posedge clkb); #1;
    start = 1'b1; base_addr = b; num_words = (AW+1)'(n); m_ready = 1'b1;
    run_active = 1'b1;
    @(posedge clkb); t_acc = $time; #1;
    start = 1'b0; base_addr = AW'($urandom); num_words = (AW+1)'($urandom);
    idx = 0; m_ready = ready_for(mode, idx);
    for (int c = 0; c < BUDGET && !seen; c++) begin
      @(negedge clkb);
      if (done) begin
        seen = 1'b1;
        lat  = int'(($time - t_acc - 5) / 10);
        check("busy_at_done", busy, 1'b1);
      end else begin
        @(posedge clkb); #1;
        idx++;
        m_ready = ready_for(mode, idx);
        if (mid) begin
          start = (idx == 3);
          base_addr = AW'($urandom);
          num_words = (AW+1)'($urandom_range(1, 9));
        end
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    if (exp_lat >= 0) check("done_latency", lat, exp_lat);
    #1;
    check("word_count", xfers, n);
    if (n > 0) check("last_word", last_data, exp_last);
    @(posedge clkb);
    @(negedge clkb);
    check("busy_after_done", busy, 1'b0);
    check("done_single", done, 1'b0);
    run_active = 1'b0;
    m_ready = 1'b0;
    $display("run %0d: base=%03h num=%0d mode=%0d words=%0d latency=%0d", tag, b, n, mode, xfers, lat);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            num;
    int            mode;
    bit            mid;
    int            lat;
    logic [DW-1:0] last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int dcnt;
    int ecnt;
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);

    vecs[0] = '{10'h005,    4, 0, 1'b0,    6, DW'(8)};      // streaming
    vecs[1] = '{10'h005,    4, 1, 1'b0,   -1, DW'(8)};      // backpressure
    vecs[2] = '{10'h3FE,    4, 0, 1'b0,    6, DW'(1)};      // address wrap
    vecs[3] = '{10'h009,    0, 0, 1'b0,    0, DW'(0)};      // zero length
    vecs[4] = '{10'h005,    4, 0, 1'b1,    6, DW'(8)};      // start while busy
    vecs[5] = '{10'h064,    1, 0, 1'b0,    3, DW'(100)};    // single word
    vecs[6] = '{10'h200, 1024, 0, 1'b0, 1026, DW'(10'h1FF)}; // whole BRAM
    vecs[7] = '{10'h3FF,    2, 1, 1'b0,   -1, DW'(0)};      // wrap + stall

    // Reset held with start asserted: everything stays at zero.
    reset = 1'b0; start = 1'b1; base_addr = 10'h005; num_words = 11'd4; m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clkb);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_enb", enb, 1'b0);
      check("rst_addrb", addrb, '0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, '0);
      check("rst_m_last", m_last, 1'b0);
`ifdef CLAUSE_RD_CHECKSUM_EN
      check("rst_checksum", checksum, '0);
`endif
    end
    $display("reset: held 3 cycles with start=1");
    @(posedge clkb); #1;
    start = 1'b0; reset = 1'b1; m_ready = 1'b0;

    for (int v = 0; v < 8; v++)
      run_case(vecs[v].base, vecs[v].num, vecs[v].mode, vecs[v].mid, vecs[v].lat, vecs[v].last, v);

    // Mid-run reset while both skid entries are full.
    @(posedge clkb); #1;
    start = 1'b1; base_addr = 10'h005; num_words = 11'd4; m_ready = 1'b0;
    @(posedge clkb); #1;
    start = 1'b0;
    @(posedge clkb); @(posedge clkb); @(posedge clkb);
    @(negedge clkb);
    check("midrst_buffered_valid", m_valid, 1'b1);
    check("midrst_buffered_head", m_data, mem[5]);
    reset = 1'b0;
    @(negedge clkb);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_m_data", m_data, '0);
    reset = 1'b1; m_ready = 1'b1;
    dcnt = 0; ecnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clkb);
      if (done) dcnt++;
      if (enb || m_valid) ecnt++;
    end
    check("midrst_no_done", dcnt, 0);
    check("midrst_no_activity", ecnt, 0);
    $display("midrun reset: done pulses=%0d activity cycles=%0d", dcnt, ecnt);
    m_ready = 1'b0;

`ifdef CLAUSE_RD_CHECKSUM_EN
    mem[10] = DW'(1); mem[11] = DW'(2); mem[12] = DW'(4);
    run_case(10'h00A, 3, 0, 1'b0, 5, DW'(4), 100);
    check("checksum_final", checksum, DW'(7));
`endif

    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] b;
      int            n;
      logic [DW-1:0] el;
      b  = AW'($urandom_range(0, DEPTH - 1));
      n  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      el = (n > 0) ? mem[(int'(b) + n - 1) % DEPTH] : '0;
      run_case(b, n, 2, 1'b0, -1, el, 200 + r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
